uart_tx_sched: RTL and testbench

Frame scheduler in front of the UART transmit FIFO. It shares the single TX FIFO write port between NREQ on-chip requesters, such as acquisition data and command responses. Each granted payload is wrapped in a fixed frame: sync, id, length, payload, checksum. A frame starts only when the FIFO has room for the whole frame, so frames are never interleaved or truncated. It runs in the `clk_h` domain and drives the UART's `tx_fifo_wen`/`tx_fifo_wdata`.

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/rr_arb.sv | 48 ++++
 rtl/uart_tx_sched.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared constants and FSM state encoding for the UART TX
//               frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

  // First byte of every frame, lets the receiver resynchronise
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Non-payload bytes per frame: sync, id, length, checksum
  localparam int FRAME_OVH = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_ID      = 3'd2,
    S_LEN     = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CSUM    = 3'd5,
    S_GAP     = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Round-robin arbiter over an eligibility mask. The search
//               starts one past the last granted requester; the pointer only
//               moves when the caller commits a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  input  logic            upd_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [1:0] last_q;
  logic       found;

  // Pick the first eligible requester at rotating offsets last+1 .. last+NREQ
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == ((int'(last_q) + k) % NREQ)) && elig_i[j]) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Remember the winner so it drops to lowest priority next round
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 2'(NREQ - 1);
    end else if (upd_i) begin
      for (int j = 0; j < NREQ; j++) begin
        if (gnt_o[j]) last_q <= 2'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares the UART TX FIFO write port between NREQ requesters.
//               Each grant emits one complete frame
//               (sync, id, len, payload, xor checksum); a frame only starts
//               when the FIFO can absorb all of it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_frame_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int UW         = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   pl_valid,
  input  logic [NREQ*8-1:0] pl_data,
  output logic [NREQ-1:0]   pl_ready,
  output logic              tx_fifo_wen,
  output logic [7:0]        tx_fifo_wdata,
  input  logic              tx_fifo_full,
  input  logic [UW-1:0]     tx_fifo_usedw,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        cur_id
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q;
  logic [1:0]        cur_id_q;
  logic [7:0]        len_q;
  logic [7:0]        rem_q;
  logic [7:0]        csum_q;
  logic              wen_q,   wen_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [31:0]       w_free;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_arb_gnt;
  logic              w_grant;
  logic [1:0]        w_win_idx;
  logic [7:0]        w_win_len;
  logic [7:0]        w_pl_byte;
  logic              w_xfer;

  // Free space seen by the scheduler; a full flag overrides a stale level
  always_comb begin
    w_free = tx_fifo_full ? 32'd0 : (32'(FIFO_DEPTH) - 32'(tx_fifo_usedw));
  end

  // A requester is eligible only if its whole frame fits right now
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign w_elig[i] = req[i] &&
                       (w_free >= (32'(req_len[8*i +: 8]) + 32'(FRAME_OVH)));
  end

  rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_i (w_elig),
    .upd_i  (w_grant),
    .gnt_o  (w_arb_gnt)
  );

  assign w_grant = (state_q == S_IDLE) && (|w_elig);

  // Decode the winner's index/length and the granted requester's payload byte
  always_comb begin
    w_win_idx = 2'd0;
    w_win_len = 8'd0;
    w_pl_byte = 8'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_arb_gnt[j]) begin
        w_win_idx = 2'(j);
        w_win_len = req_len[8*j +: 8];
      end
      if (gnt_q[j]) w_pl_byte = pl_data[8*j +: 8];
    end
  end

  assign w_xfer = |(pl_valid & pl_ready);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; header/trailer states hold while the FIFO is full
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_grant)       state_d = S_SYNC;
      S_SYNC:    if (!tx_fifo_full) state_d = S_ID;
      S_ID:      if (!tx_fifo_full) state_d = S_LEN;
      S_LEN:     if (!tx_fifo_full) state_d = (len_q == 8'd0) ? S_CSUM : S_PAYLOAD;
      S_PAYLOAD: if (w_xfer && (rem_q == 8'd1)) state_d = S_CSUM;
      S_CSUM:    if (!tx_fifo_full) state_d = S_GAP;
      S_GAP:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: FIFO write request for the current state plus status flags
  always_comb begin
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    pl_ready   = '0;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_GAP);
    case (state_q)
      S_SYNC: begin
        wen_d   = !tx_fifo_full;
        wdata_d = SYNC_BYTE;
      end
      S_ID: begin
        wen_d   = !tx_fifo_full;
        wdata_d = {6'b0, cur_id_q};
      end
      S_LEN: begin
        wen_d   = !tx_fifo_full;
        wdata_d = len_q;
      end
      S_PAYLOAD: begin
        pl_ready = gnt_q & {NREQ{!tx_fifo_full}};
        wen_d    = w_xfer;
        if (w_xfer) wdata_d = w_pl_byte;
      end
      S_CSUM: begin
        wen_d   = !tx_fifo_full;
        wdata_d = csum_q;
      end
      default: ;
    endcase
  end

  // Frame context captured at grant, payload bookkeeping, registered FIFO port
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      cur_id_q <= 2'd0;
      len_q    <= 8'd0;
      rem_q    <= 8'd0;
      csum_q   <= 8'd0;
      wen_q    <= 1'b0;
      wdata_q  <= 8'd0;
    end else begin
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      if (w_grant) begin
        gnt_q    <= w_arb_gnt;
        cur_id_q <= w_win_idx;
        len_q    <= w_win_len;
        rem_q    <= w_win_len;
        // Seed the checksum with the header bytes that precede the payload
        csum_q   <= {6'b0, w_win_idx} ^ w_win_len;
      end else begin
        // Grant spans the CSUM write, which lands during GAP
        if (state_q == S_GAP) gnt_q <= '0;
        if (w_xfer) begin
          rem_q  <= rem_q - 8'd1;
          csum_q <= csum_q ^ w_pl_byte;
        end
      end
    end
  end

  assign gnt           = gnt_q;
  assign cur_id        = cur_id_q;
  assign tx_fifo_wen   = wen_q;
  assign tx_fifo_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed testbench for uart_tx_sched with hand-computed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int UW   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   pl_valid;
  logic [NREQ*8-1:0] pl_data;
  logic [NREQ-1:0]   pl_ready;
  logic              tx_fifo_wen;
  logic [7:0]        tx_fifo_wdata;
  logic              tx_fifo_full;
  logic [UW-1:0]     tx_fifo_usedw;
  logic              busy;
  logic              frame_done;
  logic [1:0]        cur_id;

  uart_tx_sched #(
    .NREQ       (NREQ),
    .FIFO_DEPTH (4096),
    .UW         (UW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_len       (req_len),
    .gnt           (gnt),
    .pl_valid      (pl_valid),
    .pl_data       (pl_data),
    .pl_ready      (pl_ready),
    .tx_fifo_wen   (tx_fifo_wen),
    .tx_fifo_wdata (tx_fifo_wdata),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_usedw (tx_fifo_usedw),
    .busy          (busy),
    .frame_done    (frame_done),
    .cur_id        (cur_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Payload sources: per-requester byte lists consumed on handshakes
  logic [7:0] src_mem [NREQ][64];
  int         src_cnt [NREQ];
  int         src_ptr [NREQ];
  logic [NREQ-1:0] stall;

  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int         fd_cnt = 0;
  int         viol   = 0;
  logic       pr_seen = 1'b0;
  logic       full_last = 1'b0;

  always_comb begin
    pl_valid = '0;
    pl_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pl_valid[i]       = (src_ptr[i] < src_cnt[i]) && !stall[i];
      pl_data[8*i +: 8] = src_mem[i][src_ptr[i] % 64];
    end
  end

  always @(posedge clk) begin
    full_last = tx_fifo_full;
    if (tx_fifo_wen) cap_q.push_back(tx_fifo_wdata);
    if (frame_done) fd_cnt++;
    if (|pl_ready) pr_seen = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (pl_valid[i] && pl_ready[i]) src_ptr[i] <= src_ptr[i] + 1;
  end

  always @(negedge clk) begin
    if (tx_fifo_wen && full_last) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_src(input int i, input logic [7:0] b);
    src_mem[i][src_cnt[i] % 64] = b;
    src_cnt[i]++;
  endtask

  task automatic clear_obs();
    cap_q.delete();
    fd_cnt  = 0;
    pr_seen = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (cap_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_count"}, cap_q.size(), n);
  endtask

  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp, input int budget);
    int c = 0;
    while (gnt == '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_b%0d", tag, k),
            (k < cap_q.size()) ? 32'(cap_q[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, gnt, pl_ready, tx_fifo_wen, tx_fifo_wdata, busy, frame_done, cur_id};
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      src_cnt[i] = 0;
      src_ptr[i] = 0;
    end
    rst = 1'b1; req = '0; req_len = '0; tx_fifo_full = 1'b0;
    tx_fifo_usedw = '0; stall = '0;
    tick(3);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single frame, len 3, with request-to-write latency
    clear_obs();
    push_src(0, 8'h11); push_src(0, 8'h22); push_src(0, 8'h33);
    req_len = {8'd0, 8'd3};
    req = 2'b01;
    tick(1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_wen_early", 32'(tx_fifo_wen), 32'h0);
    req = 2'b00;
    tick(1);
    check("t1_wen_sync", 32'(tx_fifo_wen), 32'h1);
    check("t1_wdata_sync", 32'(tx_fifo_wdata), 32'hA5);
    wait_bytes("t1", 7, 40);
    tick(3);
    exp_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    check_bytes("t1");
    check("t1_frame_done", fd_cnt, 1);
    check("t1_idle", 32'(busy), 32'h0);

    // Round robin from a fresh reset: order 0,1,0,1
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    clear_obs();
    push_src(0, 8'hAA); push_src(0, 8'hBB);
    push_src(1, 8'hCC); push_src(1, 8'hDD);
    req_len = {8'd1, 8'd1};
    req = 2'b11;
    wait_bytes("t2", 20, 120);
    req = 2'b00;
    tick(3);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hAB,
              8'hA5, 8'h01, 8'h01, 8'hCC, 8'hCC,
              8'hA5, 8'h00, 8'h01, 8'hBB, 8'hBA,
              8'hA5, 8'h01, 8'h01, 8'hDD, 8'hDD};
    check_bytes("t2");
    check("t2_frame_done", fd_cnt, 4);

    // Space gating: free 6 blocks len 4 (needs 8) but admits len 1
    clear_obs();
    tx_fifo_usedw = 12'd4090;
    push_src(1, 8'h5E);
    push_src(0, 8'h01); push_src(0, 8'h02); push_src(0, 8'h03); push_src(0, 8'h04);
    req_len = {8'd1, 8'd4};
    req = 2'b11;
    wait_gnt("t3_gnt_short", 2'b10, 20);
    req = 2'b01;
    wait_bytes("t3a", 5, 40);
    tick(5);
    exp_q = '{8'hA5, 8'h01, 8'h01, 8'h5E, 8'h5E};
    check_bytes("t3a");
    check("t3_wait_4090", 32'(busy), 32'h0);
    tx_fifo_usedw = 12'd4089;
    tick(3);
    check("t3_wait_4089", 32'(busy), 32'h0);
    clear_obs();
    tx_fifo_usedw = 12'd4088;
    tick(1);
    check("t3_gnt_4088", 32'(gnt), 32'h1);
    req = 2'b00;
    tx_fifo_usedw = '0;
    wait_bytes("t3b", 8, 40);
    tick(3);
    exp_q = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    check_bytes("t3b");

    // Zero-length frame from requester 1
    clear_obs();
    req_len = {8'd0, 8'd0};
    req = 2'b10;
    wait_gnt("t4_gnt", 2'b10, 20);
    req = 2'b00;
    wait_bytes("t4", 4, 40);
    tick(3);
    exp_q = '{8'hA5, 8'h01, 8'h00, 8'h01};
    check_bytes("t4");
    check("t4_no_ready", 32'(pr_seen), 32'h0);
    check("t4_frame_done", fd_cnt, 1);

    // Stalls: FIFO full in SYNC and late in the frame, pl_valid gap mid-payload
    clear_obs();
    viol = 0;
    push_src(0, 8'h10); push_src(0, 8'h20); push_src(0, 8'h30); push_src(0, 8'h40);
    req_len = {8'd0, 8'd4};
    req = 2'b01;
    wait_gnt("t5_gnt", 2'b01, 20);
    req = 2'b00;
    tx_fifo_full = 1'b1;
    tick(2);
    check("t5_full_hold", 32'(tx_fifo_wen), 32'h0);
    tx_fifo_full = 1'b0;
    wait_bytes("t5a", 5, 40);
    stall[0] = 1'b1;
    tick(3);
    stall[0] = 1'b0;
    wait_bytes("t5b", 7, 40);
    tx_fifo_full = 1'b1;
    tick(2);
    tx_fifo_full = 1'b0;
    wait_bytes("t5c", 8, 40);
    tick(4);
    exp_q = '{8'hA5, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
    check_bytes("t5");
    check("t5_no_wen_when_full", viol, 0);
    check("t5_frame_done", fd_cnt, 1);

    // Reset during payload byte 2, then requester 0 must win first
    clear_obs();
    push_src(0, 8'h61); push_src(0, 8'h62); push_src(0, 8'h63);
    push_src(0, 8'h64); push_src(0, 8'h65);
    req_len = {8'd0, 8'd5};
    req = 2'b01;
    wait_gnt("t6_gnt", 2'b01, 20);
    req = 2'b00;
    wait_bytes("t6a", 5, 40);
    rst = 1'b1;
    tick(1);
    check("t6_reset_outputs", all_outs(), 32'd0);
    tick(1);
    rst = 1'b0;
    src_cnt[0] = src_ptr[0];
    tick(1);
    clear_obs();
    push_src(0, 8'h77); push_src(1, 8'h88);
    req_len = {8'd1, 8'd1};
    req = 2'b11;
    tick(1);
    check("t6_first_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    wait_bytes("t6b", 5, 40);
    tick(3);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h77, 8'h76};
    check_bytes("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
